// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the SRAM responder and the LSU initiator.
// Contents: slave FSM state enum, byte-lane SEL constants, access-size enum.
// No ports; import with wb_pkg::*.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } slave_state_t;

  localparam logic [3:0] SEL_WORD    = 4'b1111;
  localparam logic [3:0] SEL_HALF_LO = 4'b0011;
  localparam logic [3:0] SEL_HALF_HI = 4'b1100;
  localparam logic [3:0] SEL_B0      = 4'b0001;
  localparam logic [3:0] SEL_B1      = 4'b0010;
  localparam logic [3:0] SEL_B2      = 4'b0100;
  localparam logic [3:0] SEL_B3      = 4'b1000;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } access_size_t;

endpackage

// File: rtl/wishbone_sram_slave_if.sv
// Wishbone classic-cycle bus between an initiator and the SRAM responder.
// Names are from the responder's view: i_* are driven by the master, o_* by the slave.
// Signals: ADDR, DATA (both directions), WE, SEL, STB, CYC, ACK, TAGN (both directions).
interface wishbone_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] i_ADDR;
  logic [DATA_WIDTH-1:0] i_DATA;
  logic [DATA_WIDTH-1:0] o_DATA;
  logic                  i_WE;
  logic [3:0]            i_SEL;
  logic                  i_STB;
  logic                  i_CYC;
  logic                  o_ACK;
  logic                  i_TAGN;
  logic                  o_TAGN;

  modport master (
    output i_ADDR, i_DATA, i_WE, i_SEL, i_STB, i_CYC, i_TAGN,
    input  o_DATA, o_ACK, o_TAGN
  );

  modport slave (
    input  i_ADDR, i_DATA, i_WE, i_SEL, i_STB, i_CYC, i_TAGN,
    output o_DATA, o_ACK, o_TAGN
  );
endinterface

// File: rtl/wb_bram_be.sv
// DEPTH x 32 single-port memory with per-byte write enables and registered read.
// Ports: clk; we[3:0] byte-lane write enables; addr word index; wdata write word;
// rdata word at addr, registered (read-before-write on a same-edge write).
module wb_bram_be #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= r_mem[addr];
  end
endmodule

// File: rtl/wishbone_sram_slave.sv
// Wishbone classic responder over a byte-enabled word memory, WAIT_STATES wait cycles, 1-cycle ACK.
// Ports: i_CLK, i_RST (async, active-high), bus (slave modport: ADDR/DATA/WE/SEL/STB/CYC in,
// DATA/ACK/TAGN out). Misses outside [BASE_ADDR, BASE_ADDR+4*DEPTH) are ACKed, read 0, write nothing.
module wishbone_sram_slave
  import wb_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH       = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 1
) (
  input logic                  i_CLK,
  input logic                  i_RST,
  wishbone_sram_slave_if.slave bus
);
  localparam int         IDX_W   = $clog2(DEPTH);
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  slave_state_t          r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_we;
  logic [3:0]            r_sel;
  logic                  r_ack;
  logic                  r_rd_vld;

  logic                  w_in_idle;
  logic                  w_req;
  logic                  w_to_ack;
  logic [ADDR_WIDTH-1:0] w_addr_cur;
  logic [DATA_WIDTH-1:0] w_data_cur;
  logic                  w_we_cur;
  logic [3:0]            w_sel_cur;
  logic                  w_hit;
  logic [IDX_W-1:0]      w_word;
  logic [3:0]            w_bram_we;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  // With WAIT_STATES==0 the memory access happens on the very edge that samples
  // the request, so in IDLE the live bus fields stand in for the latched ones.
  always_comb begin
    w_in_idle  = (r_state == IDLE);
    w_req      = bus.i_CYC & bus.i_STB;
    w_addr_cur = w_in_idle ? bus.i_ADDR : r_addr;
    w_data_cur = w_in_idle ? bus.i_DATA : r_data;
    w_we_cur   = w_in_idle ? bus.i_WE   : r_we;
    w_sel_cur  = w_in_idle ? bus.i_SEL  : r_sel;
    // BASE_ADDR is aligned to the memory size, so a hit is a match of the bits above the index.
    w_hit      = (w_addr_cur[ADDR_WIDTH-1:IDX_W+2] == BASE_ADDR[ADDR_WIDTH-1:IDX_W+2]);
    w_word     = w_addr_cur[IDX_W+1:2];

    w_to_ack = 1'b0;
    if (w_in_idle)             w_to_ack = w_req && (WAIT_STATES == 0);
    else if (r_state == WAIT)  w_to_ack = bus.i_CYC && (r_cnt == 4'd1);

    // Write lands on the edge that enters ACK; reset suppresses it.
    w_bram_we = (w_to_ack && w_we_cur && w_hit && !i_RST) ? w_sel_cur : 4'b0000;
  end

  assign w_unused = ^{bus.i_TAGN, w_addr_cur[1:0]};

  wb_bram_be #(.DEPTH(DEPTH), .AW(IDX_W)) u_bram (
    .clk   (i_CLK),
    .we    (w_bram_we),
    .addr  (w_word),
    .wdata (w_data_cur[31:0]),
    .rdata (w_rdata)
  );

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_data   <= '0;
      r_we     <= 1'b0;
      r_sel    <= 4'b0000;
      r_ack    <= 1'b0;
      r_rd_vld <= 1'b0;
    end else begin
      r_ack    <= 1'b0;
      r_rd_vld <= 1'b0;
      if (w_to_ack) begin
        r_ack    <= 1'b1;
        r_rd_vld <= !w_we_cur && w_hit;
      end
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= bus.i_ADDR;
            r_data  <= bus.i_DATA;
            r_we    <= bus.i_WE;
            r_sel   <= bus.i_SEL;
            r_cnt   <= WS_LOAD;
            r_state <= (WAIT_STATES == 0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (!bus.i_CYC)    r_state <= IDLE;
          else if (w_to_ack) r_state <= ACK;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        ACK:     r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read data is the memory's registered output, exposed only during a read-hit ACK.
  assign bus.o_ACK  = r_ack;
  assign bus.o_DATA = r_rd_vld ? DATA_WIDTH'(w_rdata) : '0;
  assign bus.o_TAGN = 1'b0;
endmodule
